// File: rtl/seq_controller.sv
// seq_controller: multi-cycle sequencer for an 8-entry instruction store.
// It fetches, decodes and steps ADD/AND/LOAD/STORE/NOP through a two-process
// FSM. Every output is registered from the next-state decode, so outputs
// change cleanly on the clock edge and clear at once on reset.
module seq_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter bit          WRAP_EN     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [2:0] pc,
    input  logic [7:0] instr,
    output logic [7:0] ir,
    output logic       alu_en,
    output logic       alu_op,
    output logic [1:0] rf_raddr_a,
    output logic [1:0] rf_raddr_b,
    output logic [1:0] rf_waddr,
    output logic       rf_we,
    output logic       rf_wsel,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_addr,
    input  logic       mem_ack,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b10;
    localparam logic [1:0] OP_STORE  = 2'b11;
    // Wait-counter value seen on the last MEM cycle allowed without an ack.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 32'd1);

    // State and datapath registers
    state_t     r_state;
    logic [2:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_wait;
    logic       r_err;

    // Registered output strobes
    logic       r_alu_en;
    logic       r_alu_op;
    logic [1:0] r_raddr_a;
    logic [1:0] r_raddr_b;
    logic [1:0] r_waddr;
    logic       r_rf_we;
    logic       r_rf_wsel;
    logic       r_mem_req;
    logic       r_mem_we;
    logic [1:0] r_mem_addr;
    logic       r_busy;
    logic       r_halted;

    // Next-state values
    state_t     w_state_nxt;
    logic [2:0] w_pc_nxt;
    logic [7:0] w_ir_nxt;
    logic [7:0] w_wait_nxt;
    logic       w_err_nxt;

    // Next-cycle output values
    logic       w_alu_en;
    logic       w_alu_op;
    logic [1:0] w_raddr_a;
    logic [1:0] w_raddr_b;
    logic [1:0] w_waddr;
    logic       w_rf_we;
    logic       w_rf_wsel;
    logic       w_mem_req;
    logic       w_mem_we;
    logic [1:0] w_mem_addr;
    logic       w_busy;
    logic       w_halted;

    // Decode of the currently latched instruction (drives sequencing)
    logic [1:0] w_op;
    logic       w_is_nop;
    // Decode of the instruction that will be latched next cycle (drives outputs)
    logic [1:0] w_n_op;
    logic [1:0] w_n_rd;
    logic [1:0] w_n_rs;
    logic [1:0] w_n_maddr;
    // Where "advance" lands: next FETCH, or HALT after the last slot
    logic       w_at_end;
    state_t     w_adv_state;
    logic [2:0] w_adv_pc;

    assign w_op      = r_ir[7:6];
    assign w_is_nop  = (r_ir == 8'h00);
    assign w_n_op    = w_ir_nxt[7:6];
    assign w_n_rd    = w_ir_nxt[5:4];
    assign w_n_rs    = w_ir_nxt[3:2];
    assign w_n_maddr = w_ir_nxt[1:0];

    assign w_at_end    = (r_pc == 3'd7) && (WRAP_EN == 1'b0);
    assign w_adv_state = w_at_end ? ST_HALT : ST_FETCH;
    // With wrapping enabled the 3-bit increment rolls 7 back to 0 by itself.
    assign w_adv_pc    = w_at_end ? 3'd0 : (r_pc + 3'd1);

    // Next-state logic: sequencing, PC/IR update, MEM wait counter and error flag
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_wait_nxt  = r_wait;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                    w_pc_nxt    = 3'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                w_ir_nxt    = instr;
                w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_is_nop) begin
                    w_state_nxt = w_adv_state;
                    w_pc_nxt    = w_adv_pc;
                end else if (w_op[1] == 1'b0) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_MEM;
                    w_wait_nxt  = 8'd0;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_MEM: begin
                // An ack wins over a timeout landing on the same cycle.
                if (mem_ack) begin
                    w_wait_nxt = 8'd0;
                    if (w_op == OP_LOAD) begin
                        w_state_nxt = ST_WB;
                    end else begin
                        w_state_nxt = w_adv_state;
                        w_pc_nxt    = w_adv_pc;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_wait_nxt  = 8'd0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_HALT;
                    w_pc_nxt    = 3'd0;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            ST_WB: begin
                w_state_nxt = w_adv_state;
                w_pc_nxt    = w_adv_pc;
            end
            ST_HALT: begin
                if (start) begin
                    w_state_nxt = ST_FETCH;
                    w_pc_nxt    = 3'd0;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_HALT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = 3'd0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state
    always_comb begin
        w_alu_en   = 1'b0;
        w_alu_op   = 1'b0;
        w_raddr_a  = 2'd0;
        w_raddr_b  = 2'd0;
        w_waddr    = 2'd0;
        w_rf_we    = 1'b0;
        w_rf_wsel  = 1'b0;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = 2'd0;
        w_busy     = 1'b0;
        w_halted   = 1'b0;
        case (w_state_nxt)
            ST_FETCH, ST_DECODE: begin
                w_busy = 1'b1;
            end
            ST_EXEC: begin
                w_busy    = 1'b1;
                w_alu_en  = 1'b1;
                w_alu_op  = w_n_op[0];
                w_raddr_a = w_n_rd;
                w_raddr_b = w_n_rs;
            end
            ST_MEM: begin
                w_busy     = 1'b1;
                w_mem_req  = 1'b1;
                w_mem_addr = w_n_maddr;
                if (w_n_op == OP_STORE) begin
                    w_mem_we  = 1'b1;
                    w_raddr_a = w_n_rd;
                end else begin
                    w_mem_we  = 1'b0;
                end
            end
            ST_WB: begin
                w_busy    = 1'b1;
                w_rf_we   = 1'b1;
                w_waddr   = w_n_rd;
                w_rf_wsel = (w_n_op == OP_LOAD);
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset clears everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= 3'd0;
            r_ir       <= 8'h00;
            r_wait     <= 8'd0;
            r_err      <= 1'b0;
            r_alu_en   <= 1'b0;
            r_alu_op   <= 1'b0;
            r_raddr_a  <= 2'd0;
            r_raddr_b  <= 2'd0;
            r_waddr    <= 2'd0;
            r_rf_we    <= 1'b0;
            r_rf_wsel  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 2'd0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir       <= w_ir_nxt;
            r_wait     <= w_wait_nxt;
            r_err      <= w_err_nxt;
            r_alu_en   <= w_alu_en;
            r_alu_op   <= w_alu_op;
            r_raddr_a  <= w_raddr_a;
            r_raddr_b  <= w_raddr_b;
            r_waddr    <= w_waddr;
            r_rf_we    <= w_rf_we;
            r_rf_wsel  <= w_rf_wsel;
            r_mem_req  <= w_mem_req;
            r_mem_we   <= w_mem_we;
            r_mem_addr <= w_mem_addr;
            r_busy     <= w_busy;
            r_halted   <= w_halted;
        end
    end

    assign pc         = r_pc;
    assign ir         = r_ir;
    assign err        = r_err;
    assign alu_en     = r_alu_en;
    assign alu_op     = r_alu_op;
    assign rf_raddr_a = r_raddr_a;
    assign rf_raddr_b = r_raddr_b;
    assign rf_waddr   = r_waddr;
    assign rf_we      = r_rf_we;
    assign rf_wsel    = r_rf_wsel;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign busy       = r_busy;
    assign halted     = r_halted;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller. Two instances run side by side:
//   A: MEM_TIMEOUT=15, WRAP_EN=0.
//   B: MEM_TIMEOUT=4,  WRAP_EN=1.
// A reference model expands each program into an expected per-cycle trace.
// It does this straight from the instruction latencies: FETCH, DECODE, then
// EXEC+WB, MEM x (k+1) [+WB], or nothing for a NOP. The bench then compares
// every cycle against that trace.
module tb_seq_controller;

    localparam int TMO_A  = 15;
    localparam bit WRAP_A = 1'b0;
    localparam int TMO_B  = 4;
    localparam bit WRAP_B = 1'b1;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ack;
    logic sel;
    logic [7:0] prog [8];
    int         dly  [8];

    int total = 0;
    int bad   = 0;

    logic [7:0] ir_model_a;
    logic [7:0] ir_model_b;

    logic [27:0] exp_q [$];
    bit          ack_q [$];
    bit          st_q  [$];

    logic       a_start, b_start;
    logic [2:0] a_pc, b_pc;
    logic [7:0] a_instr, b_instr, a_ir, b_ir;
    logic       a_alu_en, b_alu_en, a_alu_op, b_alu_op;
    logic [1:0] a_ra, b_ra, a_rb, b_rb, a_wa, b_wa;
    logic       a_rf_we, b_rf_we, a_wsel, b_wsel;
    logic       a_mreq, b_mreq, a_mwe, b_mwe;
    logic [1:0] a_maddr, b_maddr;
    logic       a_busy, b_busy, a_halted, b_halted, a_err, b_err;
    logic [27:0] a_obs, b_obs, obs;

    always #5 clk = ~clk;

    assign a_start = start & ~sel;
    assign b_start = start & sel;
    assign a_instr = prog[a_pc];
    assign b_instr = prog[b_pc];

    assign a_obs = {a_busy, a_halted, a_err, a_alu_en, a_alu_op, a_rf_we, a_wsel,
                    a_wa, a_ra, a_rb, a_mreq, a_mwe, a_maddr, a_pc, a_ir};
    assign b_obs = {b_busy, b_halted, b_err, b_alu_en, b_alu_op, b_rf_we, b_wsel,
                    b_wa, b_ra, b_rb, b_mreq, b_mwe, b_maddr, b_pc, b_ir};
    assign obs   = sel ? b_obs : a_obs;

    seq_controller #(.MEM_TIMEOUT(TMO_A), .WRAP_EN(WRAP_A)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .pc(a_pc), .instr(a_instr), .ir(a_ir),
        .alu_en(a_alu_en), .alu_op(a_alu_op), .rf_raddr_a(a_ra), .rf_raddr_b(a_rb),
        .rf_waddr(a_wa), .rf_we(a_rf_we), .rf_wsel(a_wsel), .mem_req(a_mreq),
        .mem_we(a_mwe), .mem_addr(a_maddr), .mem_ack(ack), .busy(a_busy),
        .halted(a_halted), .err(a_err)
    );

    seq_controller #(.MEM_TIMEOUT(TMO_B), .WRAP_EN(WRAP_B)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .pc(b_pc), .instr(b_instr), .ir(b_ir),
        .alu_en(b_alu_en), .alu_op(b_alu_op), .rf_raddr_a(b_ra), .rf_raddr_b(b_rb),
        .rf_waddr(b_wa), .rf_we(b_rf_we), .rf_wsel(b_wsel), .mem_req(b_mreq),
        .mem_we(b_mwe), .mem_addr(b_maddr), .mem_ack(ack), .busy(b_busy),
        .halted(b_halted), .err(b_err)
    );

    function automatic logic [27:0] pk(input logic bsy, input logic hlt, input logic er,
                                       input logic ae, input logic ao, input logic we,
                                       input logic ws, input logic [1:0] wa,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic mr, input logic mw, input logic [1:0] ma,
                                       input logic [2:0] p, input logic [7:0] r);
        return {bsy, hlt, er, ae, ao, we, ws, wa, ra, rb, mr, mw, ma, p, r};
    endfunction

    function automatic logic [27:0] e_plain(input logic [2:0] p, input logic [7:0] r);
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0,
                  1'b0, 1'b0, 2'd0, p, r);
    endfunction

    function automatic logic [27:0] e_exec(input logic op0, input logic [1:0] rd,
                                           input logic [1:0] rs, input logic [2:0] p,
                                           input logic [7:0] r);
        return pk(1'b1, 1'b0, 1'b0, 1'b1, op0, 1'b0, 1'b0, 2'd0, rd, rs,
                  1'b0, 1'b0, 2'd0, p, r);
    endfunction

    function automatic logic [27:0] e_wb(input logic ws, input logic [1:0] rd,
                                         input logic [2:0] p, input logic [7:0] r);
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ws, rd, 2'd0, 2'd0,
                  1'b0, 1'b0, 2'd0, p, r);
    endfunction

    function automatic logic [27:0] e_mem(input logic we, input logic [1:0] ra,
                                          input logic [1:0] ma, input logic [2:0] p,
                                          input logic [7:0] r);
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ra, 2'd0,
                  1'b1, we, ma, p, r);
    endfunction

    function automatic logic [27:0] e_halt(input logic er, input logic [7:0] r);
        return pk(1'b0, 1'b1, er, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0,
                  1'b0, 1'b0, 2'd0, 3'd0, r);
    endfunction

    function automatic bit rbit();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [27:0] e, input bit a, input bit s);
        exp_q.push_back(e);
        ack_q.push_back(a);
        st_q.push_back(s);
    endtask

    // Expand prog/dly into the expected cycle-by-cycle trace for one run.
    task automatic build_trace(input bit use_b, input int max_instr, output bit ran_out);
        logic [2:0] p;
        logic [7:0] r;
        logic       e;
        logic [1:0] rd, rs, ma;
        int         n, k, nm, tmo;
        bit         wrap, done, stop;
        tmo  = use_b ? TMO_B : TMO_A;
        wrap = use_b ? WRAP_B : WRAP_A;
        exp_q.delete();
        ack_q.delete();
        st_q.delete();
        p = 3'd0;
        r = use_b ? ir_model_b : ir_model_a;
        e = 1'b0;
        n = 0;
        done = 1'b0;
        ran_out = 1'b0;
        while (!done) begin
            push(e_plain(p, r), rbit(), rbit());
            r  = prog[p];
            rd = r[5:4];
            rs = r[3:2];
            ma = r[1:0];
            push(e_plain(p, r), rbit(), rbit());
            stop = 1'b0;
            if (r != 8'h00 && r[7] == 1'b0) begin
                push(e_exec(r[6], rd, rs, p, r), rbit(), rbit());
                push(e_wb(1'b0, rd, p, r), rbit(), rbit());
            end else if (r[7] == 1'b1) begin
                k  = dly[p];
                nm = (k < tmo) ? k + 1 : tmo;
                for (int i = 0; i < nm; i++)
                    push(e_mem(r[6], r[6] ? rd : 2'd0, ma, p, r), (i == k), rbit());
                if (k >= tmo) begin
                    e = 1'b1;
                    stop = 1'b1;
                end else if (r[6] == 1'b0) begin
                    push(e_wb(1'b1, rd, p, r), rbit(), rbit());
                end
            end
            n++;
            if (stop || (p == 3'd7 && !wrap)) begin
                done = 1'b1;
            end else begin
                p = p + 3'd1;
                if (n >= max_instr) begin
                    done = 1'b1;
                    ran_out = 1'b1;
                end
            end
        end
        if (!ran_out)
            for (int i = 0; i < 3; i++) push(e_halt(e, r), rbit(), 1'b0);
        if (use_b) ir_model_b = r;
        else       ir_model_a = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("reset_a", a_obs, 28'd0);
        check("reset_b", b_obs, 28'd0);
        reset = 1'b0;
        ir_model_a = 8'h00;
        ir_model_b = 8'h00;
        @(negedge clk);
        check("idle_after_reset", obs, 28'd0);
    endtask

    // Launch one program on the selected instance and check every cycle.
    task automatic run_case(input bit use_b, input int max_instr);
        bit ran_out;
        build_trace(use_b, max_instr, ran_out);
        sel   = use_b;
        start = 1'b1;
        ack   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_cyc%0d", use_b ? "B" : "A", i), obs, exp_q[i]);
            check("strobe_excl", {27'd0, ((obs[24] + obs[22] + obs[14]) <= 2'd1)}, 28'd1);
            start = st_q[i];
            ack   = ack_q[i];
            @(negedge clk);
        end
        start = 1'b0;
        ack   = 1'b0;
        if (ran_out) do_reset();
    endtask

    task automatic rand_prog(input int max_dly);
        for (int i = 0; i < 8; i++) begin
            prog[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) prog[i] = 8'h00;
            dly[i] = int'($urandom_range(0, max_dly));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ack   = 1'b0;
        sel   = 1'b0;
        ir_model_a = 8'h00;
        ir_model_b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            prog[i] = 8'h00;
            dly[i]  = 0;
        end
        repeat (2) @(negedge clk);
        check("rst_a", a_obs, 28'd0);
        check("rst_b", b_obs, 28'd0);
        reset = 1'b0;
        ack   = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_a", a_obs, 28'd0);
        check("idle_b", b_obs, 28'd0);
        ack = 1'b0;

        // LOAD R1,m1; LOAD R2,m2; ADD R1,R2; AND R1,R2; STORE R1,m3; NOP x3
        prog = '{8'h91, 8'hA2, 8'h18, 8'h58, 8'hD3, 8'h00, 8'h00, 8'h00};
        run_case(1'b0, 100);

        // LOAD acked after five wait cycles
        prog = '{8'h92, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        dly[0] = 5;
        run_case(1'b0, 100);

        // STORE with no ack hits the 15-cycle timeout; the next start recovers
        prog = '{8'h18, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        dly[1] = 40;
        run_case(1'b0, 100);
        dly[1] = 0;
        run_case(1'b0, 100);

        for (int t = 0; t < 6; t++) begin
            rand_prog(6);
            run_case(1'b0, 100);
        end

        // Instance B: 4-cycle timeout, then recovery
        prog = '{8'hB3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) dly[i] = 0;
        dly[0] = 9;
        run_case(1'b1, 100);
        // Wrapping NOP program: pc 7 is followed by 0 while busy stays high
        prog = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_case(1'b1, 10);

        for (int t = 0; t < 4; t++) begin
            rand_prog(5);
            run_case(1'b1, 12);
        end

        // Reset while instance A waits in MEM
        sel   = 1'b0;
        prog  = '{8'h92, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midmem_req", {27'd0, a_mreq}, 28'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midmem_reset", a_obs, 28'd0);
        ack = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stray_ack%0d", i), a_obs, 28'd0);
        end
        ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of cycles spent in MEM waiting for mem_ack (range 1..255).
REQ-002 SHALL have parameter WRAP_EN, default 0, meaning: 1 = PC wraps 7->0 and execution continues; 0 = halt after the instruction at PC 7.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have clk  in  1  rising-edge clock.
REQ-005 SHALL have reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have start  in  1  begin execution from PC 0 when IDLE or HALT.
REQ-007 SHALL have pc  out  3  instruction memory address.
REQ-008 SHALL have instr  in  8  instruction memory data, combinational from pc.
REQ-009 SHALL have ir  out  8  latched instruction register.
REQ-010 SHALL have alu_en  out  1  ALU result valid strobe; alu_op  out  1  0=ADD, 1=AND.
REQ-011 SHALL have rf_raddr_a, rf_raddr_b  out  2 each  register read addresses; rf_waddr  out  2; rf_we  out  1; rf_wsel  out  1  0=ALU result, 1=memory data.
REQ-012 SHALL have mem_req  out  1; mem_we  out  1; mem_addr  out  2; mem_ack  in  1  data-memory handshake.
REQ-013 SHALL have busy  out  1; halted  out  1; err  out  1  status flags.

Function
REQ-014 SHALL decode: opcode=ir[7:6] (00 ADD, 01 AND, 10 LOAD, 11 STORE), rd=ir[5:4], rs=ir[3:2], maddr=ir[1:0]; ir==8'h00 is NOP and overrides ADD.
REQ-015 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 SHALL go IDLE->FETCH on start=1; in IDLE and HALT, pc is 0 and all strobes are 0.
REQ-017 In FETCH, SHALL latch ir<=instr and go to DECODE (1 cycle).
REQ-018 In DECODE, SHALL go: ADD/AND->EXEC, LOAD/STORE->MEM, NOP->advance (REQ-023).
REQ-019 In EXEC (1 cycle), SHALL assert alu_en=1, alu_op=opcode[0], rf_raddr_a=rd, rf_raddr_b=rs, then go to WB.
REQ-020 In MEM, SHALL hold mem_req=1 and mem_addr=maddr; mem_we=1 for STORE with rf_raddr_a=rd; mem_we=0 for LOAD; all stable until ack.
REQ-021 On mem_ack=1 in MEM, SHALL drop mem_req the next cycle; LOAD->WB, STORE->advance.
REQ-022 In WB (1 cycle), SHALL assert rf_we=1, rf_waddr=rd, rf_wsel=1 for LOAD and 0 for ALU ops, then advance.
REQ-023 Advance SHALL be: pc<=pc+1 then FETCH; at pc==7 with WRAP_EN=0, go HALT with halted=1; with WRAP_EN=1, pc<=0 then FETCH.
REQ-024 Latency (start/advance to next FETCH) SHALL be: NOP 2 cycles; ADD/AND 4; STORE 3+k; LOAD 4+k; k = cycles until ack (k>=0).
REQ-025 A wait counter SHALL count MEM cycles without ack; on reaching MEM_TIMEOUT, SHALL set err=1, drop mem_req, and go HALT.
REQ-026 mem_ack outside MEM SHALL be ignored.
REQ-027 start during FETCH..WB SHALL be ignored; start in HALT SHALL clear halted and err, set pc=0, and go FETCH.
REQ-028 busy SHALL be 1 in all states except IDLE and HALT.
REQ-029 rf_we, alu_en and mem_req SHALL never be asserted in the same cycle.

Reset
REQ-030 Reset asserted SHALL immediately force state=IDLE, pc=0, ir=0, counter=0, all strobes 0, and busy, halted, err=0, including mid-MEM (mem_req drops without waiting for ack).
REQ-031 After reset deasserts, SHALL remain IDLE until start=1.

Verification
REQ-032 Program {LOAD R1,m1; LOAD R2,m2; ADD R1,R2; AND R1,R2; STORE R1,m3; NOP; NOP; NOP}, ack on 1st MEM cycle, WRAP_EN=0 -> pc sequence 0..7, rf_we pulses with waddr 1,2,1,1; mem_we=1 only with mem_addr=3; halted=1 after NOP at 7.
REQ-033 LOAD with ack delayed 5 cycles -> mem_req high 6 cycles, addr stable, WB follows 1 cycle after ack.
REQ-034 MEM_TIMEOUT=4, no ack -> after 4 MEM cycles err=1, mem_req=0, halted=1; start -> err=0, pc=0, FETCH.
REQ-035 WRAP_EN=1, 8 NOPs -> pc 7 followed by 0, busy stays 1, each NOP is 2 cycles.
REQ-036 reset asserted mid-MEM with mem_req=1 -> same-cycle mem_req=0, pc=0, state IDLE; stray mem_ack in IDLE is ignored.
REQ-037 start pulsed during EXEC -> no effect on pc or sequence.
